// File: rtl/ovf_udf_det.sv
// rtl/ovf_udf_det.sv - overflow/underflow wrap detector and status for the 8-bit timer
//
// Watches the live timer count, flags up-count overflow (all-ones -> 0) and
// down-count underflow (0 -> all-ones), and produces a one-cycle event pulse,
// a sticky status flag with write-1-to-clear, and a registered maskable irq.
//
// Optional feature macro: OVF_UDF_EVT_CNT_EN
//   When defined, adds the EVT_CNT_W parameter and the saturating event
//   counters ovf_cnt / udf_cnt. When undefined those ports and logic are absent.
//
// Ports:
//   pclk          in   system clock, rising edge
//   preset        in   asynchronous active-high reset
//   TCNT          in   live counter value [CNT_W]
//   count_up_down in   0 = up, 1 = down
//   count_load    in   load active; a value change under load is never a wrap
//   clr_ovf       in   write-1-to-clear strobe for TMR_OVF
//   clr_udf       in   write-1-to-clear strobe for TMR_UDF
//   ovf_ie        in   overflow interrupt enable
//   udf_ie        in   underflow interrupt enable
//   ovf_pulse     out  one-cycle overflow event
//   udf_pulse     out  one-cycle underflow event
//   TMR_OVF       out  sticky overflow status
//   TMR_UDF       out  sticky underflow status
//   ovf_cnt       out  saturating overflow count [EVT_CNT_W] (macro only)
//   udf_cnt       out  saturating underflow count [EVT_CNT_W] (macro only)
//   irq           out  registered (TMR_OVF & ovf_ie) | (TMR_UDF & udf_ie)

`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module ovf_udf_det #(
    parameter int CNT_W = `DATA_WIDTH
`ifdef OVF_UDF_EVT_CNT_EN
    ,
    parameter int EVT_CNT_W = 4
`endif
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic [CNT_W-1:0] TCNT,
    input  logic             count_up_down,
    input  logic             count_load,
    input  logic             clr_ovf,
    input  logic             clr_udf,
    input  logic             ovf_ie,
    input  logic             udf_ie,
    output logic             ovf_pulse,
    output logic             udf_pulse,
    output logic             TMR_OVF,
    output logic             TMR_UDF,
`ifdef OVF_UDF_EVT_CNT_EN
    output logic [EVT_CNT_W-1:0] ovf_cnt,
    output logic [EVT_CNT_W-1:0] udf_cnt,
`endif
    output logic             irq
);

    localparam logic [CNT_W-1:0] ALL_ONES = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_pulse_q, ovf_pulse_d;
    logic             udf_pulse_q, udf_pulse_d;
    logic             tmr_ovf_q, tmr_ovf_d;
    logic             tmr_udf_q, tmr_udf_d;
    logic             irq_q, irq_d;
    logic             wrap_up;
    logic             wrap_dn;

    // Wrap detection compares the previous sample against the live value, so
    // an unchanged count can never match (0 != all-ones for any width).
    always_comb begin
        cnt_d   = TCNT;
        wrap_up = (cnt_q == ALL_ONES) && (TCNT == '0) && !count_up_down && !count_load;
        wrap_dn = (cnt_q == '0) && (TCNT == ALL_ONES) && count_up_down && !count_load;

        ovf_pulse_d = wrap_up;
        udf_pulse_d = wrap_dn;

        // Set is evaluated after clear so a same-cycle wrap keeps the flag high.
        tmr_ovf_d = tmr_ovf_q;
        if (clr_ovf) tmr_ovf_d = 1'b0;
        if (wrap_up) tmr_ovf_d = 1'b1;

        tmr_udf_d = tmr_udf_q;
        if (clr_udf) tmr_udf_d = 1'b0;
        if (wrap_dn) tmr_udf_d = 1'b1;

        // Built from next-state flags so irq moves on the same edge as the flags.
        irq_d = (tmr_ovf_d & ovf_ie) | (tmr_udf_d & udf_ie);
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            cnt_q       <= '0;
            ovf_pulse_q <= 1'b0;
            udf_pulse_q <= 1'b0;
            tmr_ovf_q   <= 1'b0;
            tmr_udf_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            ovf_pulse_q <= ovf_pulse_d;
            udf_pulse_q <= udf_pulse_d;
            tmr_ovf_q   <= tmr_ovf_d;
            tmr_udf_q   <= tmr_udf_d;
            irq_q       <= irq_d;
        end
    end

    assign ovf_pulse = ovf_pulse_q;
    assign udf_pulse = udf_pulse_q;
    assign TMR_OVF   = tmr_ovf_q;
    assign TMR_UDF   = tmr_udf_q;
    assign irq       = irq_q;

`ifdef OVF_UDF_EVT_CNT_EN
    localparam logic [EVT_CNT_W-1:0] EVT_MAX = '1;
    localparam logic [EVT_CNT_W-1:0] EVT_ONE = EVT_CNT_W'(1);

    logic [EVT_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [EVT_CNT_W-1:0] udf_cnt_q, udf_cnt_d;

    // A clear coinciding with a wrap counts that wrap, so the result is 1.
    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (clr_ovf)
            ovf_cnt_d = wrap_up ? EVT_ONE : '0;
        else if (wrap_up && (ovf_cnt_q != EVT_MAX))
            ovf_cnt_d = ovf_cnt_q + EVT_ONE;

        udf_cnt_d = udf_cnt_q;
        if (clr_udf)
            udf_cnt_d = wrap_dn ? EVT_ONE : '0;
        else if (wrap_dn && (udf_cnt_q != EVT_MAX))
            udf_cnt_d = udf_cnt_q + EVT_ONE;
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            ovf_cnt_q <= '0;
            udf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            udf_cnt_q <= udf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign udf_cnt = udf_cnt_q;
`endif

endmodule

// File: tb/tb_ovf_udf_det.sv
// tb/tb_ovf_udf_det.sv - scoreboard bench for ovf_udf_det
module tb_ovf_udf_det;

    logic       pclk = 1'b0;
    logic       preset = 1'b0;
    logic [7:0] TCNT = 8'h00;
    logic       count_up_down = 1'b0;
    logic       count_load = 1'b0;
    logic       clr_ovf = 1'b0;
    logic       clr_udf = 1'b0;
    logic       ovf_ie = 1'b0;
    logic       udf_ie = 1'b0;
    logic       ovf_pulse, udf_pulse, TMR_OVF, TMR_UDF, irq;
`ifdef OVF_UDF_EVT_CNT_EN
    logic [3:0] ovf_cnt, udf_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic op, up, fo, fu, irq;
        int   oc, uc;
    } exp_t;
    exp_t exp_q[$];

    ovf_udf_det #(
        .CNT_W(8)
`ifdef OVF_UDF_EVT_CNT_EN
        , .EVT_CNT_W(4)
`endif
    ) dut (
        .pclk(pclk),
        .preset(preset),
        .TCNT(TCNT),
        .count_up_down(count_up_down),
        .count_load(count_load),
        .clr_ovf(clr_ovf),
        .clr_udf(clr_udf),
        .ovf_ie(ovf_ie),
        .udf_ie(udf_ie),
        .ovf_pulse(ovf_pulse),
        .udf_pulse(udf_pulse),
        .TMR_OVF(TMR_OVF),
        .TMR_UDF(TMR_UDF),
`ifdef OVF_UDF_EVT_CNT_EN
        .ovf_cnt(ovf_cnt),
        .udf_cnt(udf_cnt),
`endif
        .irq(irq)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input exp_t e);
        chk({tag, ".ovf_pulse"}, int'(ovf_pulse), int'(e.op));
        chk({tag, ".udf_pulse"}, int'(udf_pulse), int'(e.up));
        chk({tag, ".TMR_OVF"},   int'(TMR_OVF),   int'(e.fo));
        chk({tag, ".TMR_UDF"},   int'(TMR_UDF),   int'(e.fu));
        chk({tag, ".irq"},       int'(irq),       int'(e.irq));
`ifdef OVF_UDF_EVT_CNT_EN
        chk({tag, ".ovf_cnt"},   int'(ovf_cnt),   e.oc);
        chk({tag, ".udf_cnt"},   int'(udf_cnt),   e.uc);
`endif
    endtask

    // Drive one cycle of inputs away from the active edge and queue the
    // registered response expected after the following rising edge.
    task automatic step(input logic [7:0] t, input logic ud, ld, co, cu, oie, uie,
                        input logic e_op, e_up, e_fo, e_fu, e_irq,
                        input int e_oc, e_uc);
        exp_t e;
        @(negedge pclk);
        TCNT = t; count_up_down = ud; count_load = ld;
        clr_ovf = co; clr_udf = cu; ovf_ie = oie; udf_ie = uie;
        e.op = e_op; e.up = e_up; e.fo = e_fo; e.fu = e_fu; e.irq = e_irq;
        e.oc = e_oc; e.uc = e_uc;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; pop one expectation per edge.
    always @(posedge pclk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk_all("cyc", e);
        end
    end

    initial begin
        exp_t z;
        z.op = 0; z.up = 0; z.fo = 0; z.fu = 0; z.irq = 0; z.oc = 0; z.uc = 0;

        // Power-on reset
        #2 preset = 1'b1;
        #1 chk_all("reset", z);
        @(negedge pclk);
        @(negedge pclk);
        preset = 1'b0;

        //     TCNT  ud ld co cu oie uie | op up fo fu irq  oc uc
        // Up count through wrap
        step(8'hFE, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,   0, 0);
        step(8'hFF, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,   0, 0);
        step(8'h00, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 1,   1, 0);
        step(8'h01, 0, 0, 0, 0, 1, 0,   0, 0, 1, 0, 1,   1, 0);
        // Clear overflow, then down count through wrap with udf_ie=0
        step(8'h01, 1, 0, 1, 0, 1, 0,   0, 0, 0, 0, 0,   0, 0);
        step(8'h00, 1, 0, 0, 0, 1, 0,   0, 0, 0, 0, 0,   0, 0);
        step(8'hFF, 1, 0, 0, 0, 1, 0,   0, 1, 0, 1, 0,   0, 1);
        step(8'hFE, 1, 0, 0, 0, 1, 1,   0, 0, 0, 1, 1,   0, 1);
        step(8'hFE, 1, 0, 0, 1, 1, 1,   0, 0, 0, 0, 0,   0, 0);
        // Load masking: load 0x00 from 0xFF, load 0xFF, then real up wrap
        step(8'hFF, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0,   0, 0);
        step(8'h00, 0, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0,   0, 0);
        step(8'hFF, 0, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0,   0, 0);
        step(8'h00, 0, 0, 0, 0, 1, 1,   1, 0, 1, 0, 1,   1, 0);
        // Halted counter: no event
        step(8'h00, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1,   1, 0);
        // Clear collides with a second wrap: flag stays, count reloads to 1
        step(8'hFF, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1,   1, 0);
        step(8'h00, 0, 0, 1, 0, 1, 1,   1, 0, 1, 0, 1,   1, 0);
        // Sixteen further back-to-back overflows; count saturates at 15
        for (int k = 1; k <= 16; k++) begin
            step(8'hFF, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1,   (k > 15) ? 15 : k, 0);
            step(8'h00, 0, 0, 0, 0, 1, 1,   1, 0, 1, 0, 1,   (k + 1 > 15) ? 15 : k + 1, 0);
        end
        // Enable change reaches irq one edge later
        step(8'h00, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0,   15, 0);
        step(8'h00, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1,   15, 0);
        step(8'hFF, 0, 0, 0, 0, 1, 1,   0, 0, 1, 0, 1,   15, 0);

        // Reset asserted while a wrap is being detected
        @(negedge pclk);
        TCNT = 8'h00;
        #2 preset = 1'b1;
        #1 chk_all("rst_mid", z);
        @(negedge pclk);
        preset = 1'b0;
        step(8'h00, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0,   0, 0);
        step(8'h00, 0, 0, 0, 0, 1, 1,   0, 0, 0, 0, 0,   0, 0);

        repeat (3) @(negedge pclk);
        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
